// File: rtl/spike_rate_decoder.sv
// Rate decoder: blanks after reset or a switch change, counts spikes over a fixed window,
// then holds a thresholded decision behind a valid/ready handshake.
// Optional XOR cross-check enabled by defining SPIKE_DECODER_XOR_CHECK_EN.
module spike_rate_decoder #(
    parameter int unsigned WINDOW_CYCLES      = 64,
    parameter int unsigned SETTLE_CYCLES      = 8,
    parameter int unsigned DECISION_THRESHOLD = 2,
    parameter int unsigned COUNT_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spike_in,
    input  logic                   switch_0,
    input  logic                   switch_1,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result,
    output logic [COUNT_WIDTH-1:0] spike_count,
    output logic                   busy,
    output logic                   mismatch_pulse,
    output logic [7:0]             mismatch_count
);

    localparam int unsigned MAX_CYC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_INTEGRATE,
        ST_HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
    logic                   result_q, result_d;
    logic [1:0]             sw_q, sw_d;
    logic                   sw_chg;
    logic                   handshake;

    always_comb begin
        sw_d        = {switch_1, switch_0};
        sw_chg      = (sw_d != sw_q);
        handshake   = (state_q == ST_HOLD) && result_ready;
        cnt_inc     = (spike_in && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        state_d     = state_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        count_out_d = count_out_q;
        result_d    = result_q;

        // A switch change wins over everything, including a same-cycle handshake.
        if (sw_chg) begin
            state_d = ST_SETTLE;
            cyc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cyc_q == SETTLE_LAST) begin
                        state_d = ST_INTEGRATE;
                        cyc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_INTEGRATE: begin
                    cnt_d = cnt_inc;
                    if (cyc_q == WIN_LAST) begin
                        state_d     = ST_HOLD;
                        cyc_d       = '0;
                        count_out_d = cnt_inc;
                        result_d    = (32'(cnt_inc) >= DECISION_THRESHOLD);
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        state_d = ST_INTEGRATE;
                        cyc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_SETTLE;
                    cyc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SETTLE;
            cyc_q       <= '0;
            cnt_q       <= '0;
            count_out_q <= '0;
            result_q    <= 1'b0;
            sw_q        <= {switch_1, switch_0};
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            count_out_q <= count_out_d;
            result_q    <= result_d;
            sw_q        <= sw_d;
        end
    end

    assign result_valid = (state_q == ST_HOLD);
    assign busy         = (state_q != ST_HOLD);
    assign result       = result_q;
    assign spike_count  = count_out_q;

`ifdef SPIKE_DECODER_XOR_CHECK_EN
    logic       mm_pulse_q, mm_pulse_d;
    logic [7:0] mm_count_q, mm_count_d;

    always_comb begin
        mm_pulse_d = handshake && (result_q != (switch_0 ^ switch_1));
        mm_count_d = (mm_pulse_d && (mm_count_q != 8'hFF)) ? mm_count_q + 8'd1 : mm_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_pulse_q <= 1'b0;
            mm_count_q <= 8'd0;
        end else begin
            mm_pulse_q <= mm_pulse_d;
            mm_count_q <= mm_count_d;
        end
    end

    assign mismatch_pulse = mm_pulse_q;
    assign mismatch_count = mm_count_q;
`else
    logic unused_hs;
    assign unused_hs      = handshake;
    assign mismatch_pulse = 1'b0;
    assign mismatch_count = 8'd0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default-parameter instance plus a long-window
// instance for counter saturation.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst, spike_in, switch_0, switch_1, result_ready;
    logic       result_valid, result, busy, mismatch_pulse;
    logic [7:0] spike_count, mismatch_count;

    logic       rst2, spike2;
    logic       valid2, result2, busy2, mm_pulse2;
    logic [7:0] count2, mm_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_rate_decoder dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .switch_0(switch_0), .switch_1(switch_1),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .spike_count(spike_count), .busy(busy), .mismatch_pulse(mismatch_pulse),
        .mismatch_count(mismatch_count)
    );

    spike_rate_decoder #(.WINDOW_CYCLES(300)) dut_sat (
        .clk(clk), .rst(rst2), .spike_in(spike2), .switch_0(1'b1), .switch_1(1'b0),
        .result_valid(valid2), .result_ready(1'b0), .result(result2),
        .spike_count(count2), .busy(busy2), .mismatch_pulse(mm_pulse2),
        .mismatch_count(mm_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; spike_in = 1'b0; switch_0 = 1'b1; switch_1 = 1'b0; result_ready = 1'b0;
        rst2 = 1'b1; spike2 = 1'b0;
        repeat (3) tick();
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", result_valid); end
        total++; if (result !== 1'b0) begin bad++; $display("FAIL reset_result got=%0b exp=0", result); end
        total++; if (spike_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", spike_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%0b exp=1", busy); end
        total++; if (mismatch_pulse !== 1'b0 || mismatch_count !== 8'd0) begin
            bad++; $display("FAIL reset_mismatch got=%0b/%0d exp=0/0", mismatch_pulse, mismatch_count); end
    endtask

    // Switches 01, 6 spikes in the window plus one during SETTLE that must be ignored.
    task automatic test_basic_window();
        rst = 1'b0;
        for (int c = 0; c < 72; c++) begin
            spike_in = (c == 3) || (c >= 10 && c <= 20 && (c % 2) == 0);
            if (c == 71) begin
                total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", result_valid); end
            end
            tick();
        end
        spike_in = 1'b0;
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", result_valid); end
        total++; if (spike_count !== 8'd6) begin bad++; $display("FAIL basic_count got=%0d exp=6", spike_count); end
        total++; if (result !== 1'b1) begin bad++; $display("FAIL basic_result got=%0b exp=1", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b exp=0", busy); end
    endtask

    // Hold 100 cycles with ready low, then handshake straight into a new window
    // whose only spike lands on the last integrate cycle.
    task automatic test_back_to_back();
        int unstable = 0;
        result_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            spike_in = (i % 3 == 0);
            tick();
            if (result_valid !== 1'b1 || result !== 1'b1 || spike_count !== 8'd6) unstable++;
        end
        spike_in = 1'b0;
        total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", unstable); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL hs_valid_drop got=%0b exp=0", result_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_busy got=%0b exp=1", busy); end
        for (int w = 0; w < 64; w++) begin
            spike_in = (w == 63);
            if (w == 63) begin
                total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0b exp=0", result_valid); end
            end
            tick();
        end
        spike_in = 1'b0;
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", result_valid); end
        total++; if (spike_count !== 8'd1) begin bad++; $display("FAIL last_cycle_spike_count got=%0d exp=1", spike_count); end
        total++; if (result !== 1'b0) begin bad++; $display("FAIL b2b_result got=%0b exp=0", result); end
    endtask

    // Switch change to 11 in the same cycle as a handshake: SETTLE wins, then 1 spike -> result 0.
    task automatic test_switch_handshake();
        switch_0 = 1'b1; switch_1 = 1'b1; result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL swhs_valid got=%0b exp=0", result_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL swhs_busy got=%0b exp=1", busy); end
        for (int c = 0; c < 72; c++) begin
            spike_in = (c == 40);
            if (c == 71) begin
                total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL swhs_settle_gap got=%0b exp=0", result_valid); end
            end
            tick();
        end
        spike_in = 1'b0;
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL sw11_valid got=%0b exp=1", result_valid); end
        total++; if (spike_count !== 8'd1) begin bad++; $display("FAIL sw11_count got=%0d exp=1", spike_count); end
        total++; if (result !== 1'b0) begin bad++; $display("FAIL sw11_result got=%0b exp=0", result); end
    endtask

    // Mid-window reset abort, then a 01->10 change at window cycle 30 with spikes in the following SETTLE.
    task automatic test_abort_and_switch();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        spike_in = 1'b1;
        repeat (20) tick();
        spike_in = 1'b0;
        rst = 1'b1; switch_0 = 1'b1; switch_1 = 1'b0;
        repeat (2) tick();
        total++; if (result_valid !== 1'b0 || spike_count !== 8'd0) begin
            bad++; $display("FAIL abort got valid=%0b count=%0d exp valid=0 count=0", result_valid, spike_count); end
        rst = 1'b0;
        for (int c = 0; c < 38; c++) begin
            spike_in = (c == 20) || (c == 25);
            tick();
        end
        spike_in = 1'b0; switch_0 = 1'b0; switch_1 = 1'b1;
        tick();
        total++; if (result_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL swchg_state got valid=%0b busy=%0b exp valid=0 busy=1", result_valid, busy); end
        for (int c = 0; c < 72; c++) begin
            spike_in = (c == 1) || (c == 3) || (c == 5) || (c == 7) || (c == 50) || (c == 60);
            if (c == 71) begin
                total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL swchg_early_valid got=%0b exp=0", result_valid); end
            end
            tick();
        end
        spike_in = 1'b0;
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL swchg_valid got=%0b exp=1", result_valid); end
        total++; if (spike_count !== 8'd2) begin bad++; $display("FAIL swchg_count got=%0d exp=2", spike_count); end
        total++; if (result !== 1'b1) begin bad++; $display("FAIL threshold_edge_result got=%0b exp=1", result); end
    endtask

    task automatic test_xor_check();
        logic       exp_pulse;
        logic [7:0] exp_cnt;
`ifdef SPIKE_DECODER_XOR_CHECK_EN
        exp_pulse = 1'b1; exp_cnt = 8'd1;
`else
        exp_pulse = 1'b0; exp_cnt = 8'd0;
`endif
        switch_0 = 1'b0; switch_1 = 1'b0;
        tick();
        for (int c = 0; c < 72; c++) begin
            spike_in = (c == 20) || (c == 30) || (c == 40);
            tick();
        end
        spike_in = 1'b0;
        total++; if (result_valid !== 1'b1 || spike_count !== 8'd3) begin
            bad++; $display("FAIL xor_window got valid=%0b count=%0d exp valid=1 count=3", result_valid, spike_count); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        total++; if (mismatch_pulse !== exp_pulse) begin bad++; $display("FAIL mm_pulse got=%0b exp=%0b", mismatch_pulse, exp_pulse); end
        total++; if (mismatch_count !== exp_cnt) begin bad++; $display("FAIL mm_count got=%0d exp=%0d", mismatch_count, exp_cnt); end
        tick();
        total++; if (mismatch_pulse !== 1'b0) begin bad++; $display("FAIL mm_pulse_width got=%0b exp=0", mismatch_pulse); end
        total++; if (mismatch_count !== exp_cnt) begin bad++; $display("FAIL mm_count_hold got=%0d exp=%0d", mismatch_count, exp_cnt); end
    endtask

    task automatic test_saturate();
        rst2 = 1'b0; spike2 = 1'b1;
        repeat (307) tick();
        total++; if (valid2 !== 1'b0) begin bad++; $display("FAIL sat_early_valid got=%0b exp=0", valid2); end
        tick();
        total++; if (valid2 !== 1'b1) begin bad++; $display("FAIL sat_valid got=%0b exp=1", valid2); end
        total++; if (count2 !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", count2); end
        total++; if (result2 !== 1'b1) begin bad++; $display("FAIL sat_result got=%0b exp=1", result2); end
        spike2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_back_to_back();
        test_switch_handshake();
        test_abort_and_switch();
        test_xor_check();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
